// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, imem req/ack handshake and a one-entry skid buffer.
// Optional trace output is enabled by defining FETCH_TRACE_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8002_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        redirect,
    input  logic [0:31] redirect_pc,
    output logic [0:31] pc,
    output logic [0:31] insn,
    output logic        valid_insn,
    output logic [31:0] insn_count
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FULL
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] fetch_pc, fetch_pc_n;
    logic            drop, drop_n;
    logic            skid_valid, skid_valid_n;
    logic [XLEN-1:0] skid_pc, skid_pc_n;
    logic [XLEN-1:0] skid_insn, skid_insn_n;
    logic [0:XLEN-1] pc_n, insn_n;
    logic            valid_n;
    logic [XLEN-1:0] count_n;
    logic            req_n;
    logic            consume;
    logic            slot_free;

    // The address register doubles as the fetch pointer.
    assign imem_addr = fetch_pc;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        drop_n       = drop;
        skid_valid_n = skid_valid;
        skid_pc_n    = skid_pc;
        skid_insn_n  = skid_insn;
        pc_n         = pc;
        insn_n       = insn;
        consume      = valid_insn && !stall && !redirect;
        slot_free    = !valid_insn || consume;
        valid_n      = valid_insn && !consume;
        count_n      = insn_count + XLEN'(consume);

        if (redirect) begin
            valid_n      = 1'b0;
            skid_valid_n = 1'b0;
            fetch_pc_n   = {redirect_pc[0:XLEN-3], 2'b00};
            // An unanswered request cannot be retracted, so its response is dropped later.
            if (state == BUSY && !imem_ack) begin
                state_n = BUSY;
                drop_n  = 1'b1;
            end else begin
                state_n = IDLE;
                drop_n  = 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!skid_valid) begin
                        state_n = BUSY;
                    end
                end
                BUSY: begin
                    if (imem_ack) begin
                        if (drop) begin
                            drop_n = 1'b0;
                        end else begin
                            fetch_pc_n = fetch_pc + XLEN'(PC_STEP);
                            if (slot_free) begin
                                pc_n    = fetch_pc;
                                insn_n  = imem_rdata;
                                valid_n = 1'b1;
                            end else begin
                                skid_valid_n = 1'b1;
                                skid_pc_n    = fetch_pc;
                                skid_insn_n  = imem_rdata;
                                state_n      = FULL;
                            end
                        end
                    end
                end
                FULL: begin
                    if (slot_free) begin
                        pc_n         = skid_pc;
                        insn_n       = skid_insn;
                        valid_n      = 1'b1;
                        skid_valid_n = 1'b0;
                        state_n      = BUSY;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        req_n = (state_n == BUSY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            drop       <= 1'b0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_insn  <= '0;
            pc         <= RESET_PC;
            insn       <= '0;
            valid_insn <= 1'b0;
            insn_count <= '0;
            imem_req   <= 1'b0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            drop       <= drop_n;
            skid_valid <= skid_valid_n;
            skid_pc    <= skid_pc_n;
            skid_insn  <= skid_insn_n;
            pc         <= pc_n;
            insn       <= insn_n;
            valid_insn <= valid_n;
            insn_count <= count_n;
            imem_req   <= req_n;
        end
    end

`ifdef FETCH_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (consume) begin
                $display("PC: %h Instruction: %h", pc, insn);
            end
            if (redirect) begin
                $display("redirect -> %h", redirect_pc);
            end
        end
    end
`endif

endmodule
